// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Types and constants shared by the serial shift-register
//                transmitter and the serial word receiver.
//                  rx_state_t        receiver FSM states
//                  DIR_LSB_FIRST     bit order code for right-shift senders
//                  DIR_MSB_FIRST     bit order code for left-shift senders
//                  SER_WIDTH_DEFAULT default serial word width
//  Revision    : 1.0  initial release
// ============================================================================
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } rx_state_t;

    localparam logic DIR_LSB_FIRST     = 1'b0;
    localparam logic DIR_MSB_FIRST     = 1'b1;
    localparam int   SER_WIDTH_DEFAULT = 8;

endpackage : serial_pkg
`default_nettype wire

// File: rtl/serial_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : serial_bit_counter
//  Description : Bit position counter for the serial word receiver.
//                The clear acts before the increment, so clr&inc loads 1
//                (used when a frame_start bit is counted as bit 0).
//  Ports       : clk    rising-edge clock
//                rst_n  asynchronous active-low reset
//                clr    return count to zero (before increment)
//                inc    add one to the count
//                tc     count equals WIDTH-1 (next data bit is the last)
//  Revision    : 1.0  initial release
// ============================================================================
module serial_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int                 c_CNT_W  = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_TC_VAL = c_CNT_W'(WIDTH - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || inc) begin
            r_cnt <= (clr ? '0 : r_cnt) + {{(c_CNT_W-1){1'b0}}, inc};
        end
    end

    assign tc = (r_cnt == c_TC_VAL);

endmodule : serial_bit_counter
`default_nettype wire

// File: rtl/serial_word_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_receiver
//  Description : Collects WIDTH serial bits (one per ser_valid cycle) into a
//                parallel word, LSB-first or MSB-first per frame, and holds
//                the completed word behind a valid/ready handshake.
//                Optional feature macro: SERIAL_RX_PARITY_EN (one trailing
//                even-parity bit per frame, checked into parity_err).
//  Ports       : clk, rst_n           clock, async active-low reset
//                ser_in, ser_valid    serial bit and its qualifier
//                frame_start          this qualified bit is bit 0 of a frame
//                dir                  0 LSB-first, 1 MSB-first (at frame_start)
//                data_out, out_valid  held word and its valid flag
//                out_ready            consumer accepts the held word
//                busy                 frame partially received
//                overrun              pulse: completed word dropped
//                frame_abort          pulse: partial frame restarted
//                parity_err           parity result of data_out
//  Revision    : 1.0  initial release
// ============================================================================
module serial_word_receiver
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             frame_start,
    input  logic             dir,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_abort,
    output logic             parity_err
);

    rx_state_t        r_state;
    logic             r_dir;
    logic [WIDTH-1:0] r_sr;

    logic             w_start;
    logic             w_data_bit;
    logic             w_tc;
    logic             w_complete;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] w_sr_next;

    assign w_start    = ser_valid & frame_start;
    assign w_data_bit = ser_valid & ~frame_start & (r_state == SHIFT);

    // Bit 0 of a frame starts from a clean register so a restarted frame
    // can never inherit bits of the aborted one.
    always_comb begin
        w_sr_next = r_sr;
        if (w_start) begin
            if (dir == DIR_MSB_FIRST) begin
                w_sr_next = {{(WIDTH-1){1'b0}}, ser_in};
            end else begin
                w_sr_next = {ser_in, {(WIDTH-1){1'b0}}};
            end
        end else if (r_dir == DIR_MSB_FIRST) begin
            w_sr_next = {r_sr[WIDTH-2:0], ser_in};
        end else begin
            w_sr_next = {ser_in, r_sr[WIDTH-1:1]};
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    logic w_par;
    // The word is complete in r_sr; the bit arriving in PAR is parity.
    assign w_complete = ser_valid & ~frame_start & (r_state == PAR);
    assign w_word     = r_sr;
    assign w_par      = ^{r_sr, ser_in};
`else
    assign w_complete = w_data_bit & w_tc;
    assign w_word     = w_sr_next;
    assign parity_err = 1'b0;
`endif

    // Count holds at WIDTH-1 on the last data bit; it is cleared when the
    // word completes or reloaded to 1 by a frame_start.
    serial_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_start | w_complete),
        .inc   (w_start | (w_data_bit & ~w_tc)),
        .tc    (w_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_dir       <= DIR_LSB_FIRST;
            r_sr        <= '0;
            data_out    <= '0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
            frame_abort <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            overrun     <= 1'b0;
            frame_abort <= 1'b0;

            if (w_start) begin
                r_dir       <= dir;
                r_sr        <= w_sr_next;
                r_state     <= SHIFT;
                frame_abort <= (r_state != IDLE);
            end else if (w_data_bit) begin
                r_sr <= w_sr_next;
                if (w_tc) begin
`ifdef SERIAL_RX_PARITY_EN
                    r_state <= PAR;
`else
                    r_state <= IDLE;
`endif
                end
            end else if (w_complete) begin
                r_state <= IDLE;
            end

            // A consume in the completion cycle frees the holding register
            // in time for the new word (zero-bubble hand-over).
            if (w_complete) begin
                if (!out_valid || out_ready) begin
                    data_out   <= w_word;
                    out_valid  <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                    parity_err <= w_par;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (r_state != IDLE);

endmodule : serial_word_receiver
`default_nettype wire

// File: tb/tb_serial_word_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_word_receiver
//  Description : Self-checking bench for serial_word_receiver. A frame-level
//                reference model collects accepted bits in a queue and
//                assembles words arithmetically when a frame is full.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_word_receiver;

    localparam int WIDTH = 8;
`ifdef SERIAL_RX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int FRAME_LEN = WIDTH + PAR_EN;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ser_in;
    logic             ser_valid;
    logic             frame_start;
    logic             dir;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overrun;
    logic             frame_abort;
    logic             parity_err;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic             bits[$];
    logic             m_dir;
    logic             m_in_frame;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_perr;
    logic             m_ovr;
    logic             m_abort;

    serial_word_receiver #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ser_in      (ser_in),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .dir         (dir),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .overrun     (overrun),
        .frame_abort (frame_abort),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] assemble(input logic d);
        logic [WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (d) w[WIDTH-1-i] = bits[i];
            else   w[i]         = bits[i];
        end
        return w;
    endfunction

    function automatic logic frame_parity();
        logic p;
        p = 1'b0;
        foreach (bits[i]) p = p ^ bits[i];
        return p;
    endfunction

    task automatic model_reset();
        bits.delete();
        m_dir      = 1'b0;
        m_in_frame = 1'b0;
        m_valid    = 1'b0;
        m_data     = '0;
        m_perr     = 1'b0;
        m_ovr      = 1'b0;
        m_abort    = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"},  32'(data_out),    32'(m_data));
        chk({tag, ".valid"}, 32'(out_valid),   32'(m_valid));
        chk({tag, ".busy"},  32'(busy),        32'(m_in_frame));
        chk({tag, ".ovr"},   32'(overrun),     32'(m_ovr));
        chk({tag, ".abort"}, 32'(frame_abort), 32'(m_abort));
        chk({tag, ".perr"},  32'(parity_err),  32'(m_perr));
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic step(input logic sv, input logic fs, input logic d,
                        input logic b, input logic rdy, input string tag);
        logic             complete;
        logic [WIDTH-1:0] word;
        logic             perr;
        ser_valid   = sv;
        frame_start = fs;
        dir         = d;
        ser_in      = b;
        out_ready   = rdy;
        complete = 1'b0;
        word     = '0;
        perr     = 1'b0;
        m_ovr    = 1'b0;
        m_abort  = 1'b0;
        if (sv) begin
            if (fs) begin
                m_abort = m_in_frame;
                bits.delete();
                m_dir      = d;
                m_in_frame = 1'b1;
                bits.push_back(b);
            end else if (m_in_frame) begin
                bits.push_back(b);
                if (bits.size() == FRAME_LEN) begin
                    complete   = 1'b1;
                    word       = assemble(m_dir);
                    perr       = (PAR_EN != 0) ? frame_parity() : 1'b0;
                    m_in_frame = 1'b0;
                    bits.delete();
                end
            end
        end
        if (complete) begin
            if (!m_valid || rdy) begin
                m_data  = word;
                m_valid = 1'b1;
                m_perr  = perr;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input logic rdy, input string tag);
        step(1'b0, 1'b0, 1'b0, 1'b0, rdy, tag);
    endtask

    // Send a whole frame; out_ready is 0 except on the final bit.
    task automatic send_word(input logic [WIDTH-1:0] w, input logic d, input int gap,
                             input logic par, input logic rdy_last, input string tag);
        logic b;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (i < WIDTH) b = d ? w[WIDTH-1-i] : w[i];
            else           b = par;
            step(1'b1, (i == 0), d, b, (i == FRAME_LEN-1) ? rdy_last : 1'b0, tag);
            if (i != FRAME_LEN-1) begin
                for (int g = 0; g < gap; g++) idle(1'b0, tag);
            end
        end
    endtask

    function automatic logic even_par(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction

    initial begin
        model_reset();
        rst_n = 1'b0; ser_in = 1'b0; ser_valid = 1'b0;
        frame_start = 1'b0; dir = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        idle(1'b0, "post_reset");

        // 1: LSB-first A5 back-to-back
        send_word(8'hA5, 1'b0, 0, even_par(8'hA5), 1'b0, "t1");
        chk("t1.data_const", 32'(data_out), 32'hA5);
        chk("t1.valid_const", 32'(out_valid), 32'd1);
        chk("t1.busy_const", 32'(busy), 32'd0);
        idle(1'b1, "t1.consume");
        idle(1'b0, "t1.empty");
        chk("t1.data_kept", 32'(data_out), 32'hA5);

        // 2: MSB-first 3C with 2-cycle gaps
        send_word(8'h3C, 1'b1, 2, even_par(8'h3C), 1'b0, "t2");
        chk("t2.data_const", 32'(data_out), 32'h3C);
        idle(1'b1, "t2.consume");

        // 3: overrun, then zero-bubble replacement
        send_word(8'hA5, 1'b0, 0, even_par(8'hA5), 1'b0, "t3a");
        send_word(8'h11, 1'b0, 0, even_par(8'h11), 1'b0, "t3b");
        chk("t3.ovr_const", 32'(overrun), 32'd1);
        chk("t3.data_held", 32'(data_out), 32'hA5);
        idle(1'b0, "t3.ovr_end");
        chk("t3.ovr_pulse", 32'(overrun), 32'd0);
        send_word(8'h11, 1'b0, 0, even_par(8'h11), 1'b1, "t3c");
        chk("t3.data_new", 32'(data_out), 32'h11);
        chk("t3.valid_kept", 32'(out_valid), 32'd1);

        // 4: partial frame aborted by a new frame_start
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "t4.p0");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t4.p1");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "t4.p2");
        send_word(8'hFF, 1'b0, 0, even_par(8'hFF), 1'b1, "t4");
        chk("t4.data_const", 32'(data_out), 32'hFF);

        // 5: async reset mid-frame
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "t5.b0");
        for (int i = 1; i < 5; i++) step(1'b1, 1'b0, 1'b1, i[0], 1'b0, "t5.b");
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("t5.async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "t5.ignored");
        send_word(8'h5A, 1'b0, 0, even_par(8'h5A), 1'b0, "t5");
        chk("t5.data_const", 32'(data_out), 32'h5A);
        idle(1'b1, "t5.consume");

`ifdef SERIAL_RX_PARITY_EN
        // 6: parity good and bad, both delivered
        send_word(8'h07, 1'b0, 0, 1'b1, 1'b0, "t6a");
        chk("t6.perr_good", 32'(parity_err), 32'd0);
        chk("t6.data_a", 32'(data_out), 32'h07);
        idle(1'b1, "t6.consume");
        send_word(8'h07, 1'b0, 0, 1'b0, 1'b0, "t6b");
        chk("t6.perr_bad", 32'(parity_err), 32'd1);
        chk("t6.valid_b", 32'(out_valid), 32'd1);
        idle(1'b1, "t6.consume2");
`endif

        // random traffic against the model
        for (int c = 0; c < 600; c++) begin
            logic sv, fs;
            sv = ($urandom_range(0, 3) != 0);
            fs = m_in_frame ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0);
            step(sv, fs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_serial_word_receiver
`default_nettype wire
